// File: rtl/deser_frame_ctrl.sv
// deser_frame_ctrl
// Frame controller for the 8-bit serial-to-parallel path. Hunts the serial
// bitstream for SYNC_BYTE, reads a length byte, frames that many payload bytes
// and checks a trailing XOR checksum byte. Payload bytes are offered to the
// consumer through a one-entry valid/ready output register.
//
// Ports
//   clock_in     single system clock, rising edge
//   reset        synchronous, active-high reset
//   bit_valid    Data_in is sampled only when 1
//   Data_in      serial bit, MSB of each byte first
//   Data_out     payload byte
//   data_valid   Data_out holds an undelivered payload byte
//   data_ready   consumer accepts Data_out when data_valid=1
//   frame_start  one-cycle pulse after the last SYNC bit
//   frame_end    one-cycle pulse after the last CHK bit or a bad LEN byte
//   frame_err    status of the last completed frame, updated with frame_end
//   overflow     sticky, a payload byte was dropped
//   state        debug: 0 HUNT, 1 LEN, 2 PAYLOAD, 3 CHK
module deser_frame_ctrl #(
   parameter logic [7:0]  SYNC_BYTE = 8'hA5,
   parameter int unsigned MAX_LEN   = 16
) (
   input  logic       clock_in,
   input  logic       reset,
   input  logic       bit_valid,
   input  logic       Data_in,
   output logic [7:0] Data_out,
   output logic       data_valid,
   input  logic       data_ready,
   output logic       frame_start,
   output logic       frame_end,
   output logic       frame_err,
   output logic       overflow,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      StHunt    = 2'd0,
      StLen     = 2'd1,
      StPayload = 2'd2,
      StChk     = 2'd3
   } state_e;

   state_e     state_q, state_d;
   logic [7:0] shift_q, shift_d;
   logic [3:0] fill_q, fill_d;       // bits seen since HUNT entry, saturates at 8
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] rem_q, rem_d;         // payload bytes still to come
   logic [7:0] chk_q, chk_d;
   logic [7:0] data_q, data_d;
   logic       valid_q, valid_d;
   logic       start_q, start_d;
   logic       end_q, end_d;
   logic       err_q, err_d;
   logic       ovf_q, ovf_d;

   logic       byte_done;
   logic       pay_byte;
   logic       len_ok;

   // Framing: shift register, counters, checksum and state.
   always_comb begin
      shift_d   = shift_q;
      fill_d    = fill_q;
      bit_cnt_d = bit_cnt_q;
      rem_d     = rem_q;
      chk_d     = chk_q;
      state_d   = state_q;
      start_d   = 1'b0;
      end_d     = 1'b0;
      err_d     = err_q;
      byte_done = 1'b0;
      pay_byte  = 1'b0;

      if (bit_valid) begin
         shift_d = {shift_q[6:0], Data_in};
         if (state_q == StHunt) begin
            fill_d = (fill_q == 4'd8) ? 4'd8 : fill_q + 4'd1;
            // The fill guard stops stale pre-HUNT bits from forming a match.
            if (fill_d == 4'd8 && shift_d == SYNC_BYTE) begin
               state_d   = StLen;
               start_d   = 1'b1;
               bit_cnt_d = 3'd0;
            end
         end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            byte_done = (bit_cnt_q == 3'd7);
         end
      end

      len_ok = (shift_d != 8'd0) && (32'(shift_d) <= MAX_LEN);

      if (byte_done) begin
         case (state_q)
            StLen: begin
               if (len_ok) begin
                  state_d = StPayload;
                  rem_d   = shift_d;
                  chk_d   = 8'd0;
               end else begin
                  state_d = StHunt;
                  fill_d  = 4'd0;
                  end_d   = 1'b1;
                  err_d   = 1'b1;
               end
            end
            StPayload: begin
               pay_byte = 1'b1;
               chk_d    = chk_q ^ shift_d;
               rem_d    = rem_q - 8'd1;
               if (rem_q == 8'd1) begin
                  state_d = StChk;
               end
            end
            StChk: begin
               state_d = StHunt;
               fill_d  = 4'd0;
               end_d   = 1'b1;
               err_d   = (shift_d != chk_q);
            end
            default: ;
         endcase
      end
   end

   // One-entry output register; a byte arriving while the held one is
   // stalled is dropped but has already been folded into the checksum.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      ovf_d   = ovf_q;
      if (pay_byte) begin
         if (!valid_q || data_ready) begin
            data_d  = shift_d;
            valid_d = 1'b1;
         end else begin
            ovf_d = 1'b1;
         end
      end else if (valid_q && data_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock_in) begin
      if (reset) begin
         state_q   <= StHunt;
         shift_q   <= 8'd0;
         fill_q    <= 4'd0;
         bit_cnt_q <= 3'd0;
         rem_q     <= 8'd0;
         chk_q     <= 8'd0;
         data_q    <= 8'd0;
         valid_q   <= 1'b0;
         start_q   <= 1'b0;
         end_q     <= 1'b0;
         err_q     <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         fill_q    <= fill_d;
         bit_cnt_q <= bit_cnt_d;
         rem_q     <= rem_d;
         chk_q     <= chk_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         start_q   <= start_d;
         end_q     <= end_d;
         err_q     <= err_d;
         ovf_q     <= ovf_d;
      end
   end

   assign Data_out    = data_q;
   assign data_valid  = valid_q;
   assign frame_start = start_q;
   assign frame_end   = end_q;
   assign frame_err   = err_q;
   assign overflow    = ovf_q;
   assign state       = state_q;

endmodule

// File: doc/deser_frame_ctrl.md
Name: deser_frame_ctrl

Overview:
Frame controller that sequences the 8-bit serial-to-parallel path.
- Hunts the incoming serial bitstream for a sync byte, then reads a length byte and frames that many payload bytes, followed by an XOR checksum byte.
- Delivers payload bytes to the downstream consumer over a valid/ready handshake.
- Reports frame boundaries, checksum/length errors and overflow.
- Sits between the serial line sampler and the byte-wide consumer logic.

Parameters:
SYNC_BYTE, 8'hA5, frame sync pattern, MSB first.
MAX_LEN, 16, largest legal payload length (1..255).

Ports:
clock_in  input  1  single system clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
bit_valid  input  1  Data_in is sampled only in cycles where this is 1.
Data_in  input  1  serial data bit, MSB of each byte first.
Data_out  output  8  payload byte.
data_valid  output  1  Data_out holds an undelivered payload byte.
data_ready  input  1  consumer accepts Data_out when data_valid=1.
frame_start  output  1  one-cycle pulse, the cycle after the last SYNC bit.
frame_end  output  1  one-cycle pulse, the cycle after the last CHK bit or an invalid LEN byte.
frame_err  output  1  status of the last completed frame; updated on frame_end.
overflow  output  1  sticky; a payload byte was dropped.
state  output  2  debug: 0 HUNT, 1 LEN, 2 PAYLOAD, 3 CHK.

Behaviour:
- Reset (sync, active-high): all outputs 0, state=HUNT, shift register=0, bit/byte counters=0, hunt fill count=0, checksum accumulator=0. Reset overrides all other events in the same cycle. Reset mid-frame abandons the frame; no frame_end is issued.
- bit_valid=0: no shifting and no counter or state change. The handshake still operates.
- Shift register: on bit_valid, shifts left with Data_in entering the LSB.
- HUNT:
  - Fill count saturates at 8 and is cleared on every HUNT entry.
  - Match when fill≥8 and the post-shift value equals SYNC_BYTE → LEN; frame_start=1 next cycle; bit count=0.
  - No match is allowed on fewer than 8 bits since HUNT entry.
- Byte completion: the 8th bit_valid after entering LEN, PAYLOAD or CHK completes a byte (value = post-shift register). The bit counter wraps 7→0.
- LEN:
  - Completed byte L with 1≤L≤MAX_LEN → PAYLOAD; remaining count=L; checksum=0.
  - L=0 or L>MAX_LEN → HUNT; frame_end=1 and frame_err=1 next cycle; no payload delivered.
- PAYLOAD:
  - Each completed byte XORs into the checksum and is offered to the output register; remaining count decrements.
  - When the count reaches 0 → CHK.
- CHK: completed byte compared to the checksum → HUNT; next cycle frame_end=1 and frame_err=(mismatch).
- frame_err holds until the next frame_end or reset.
- Output register, with latency of 1 cycle from the completing bit to data_valid=1:
  - Load when data_valid=0, or when data_valid=1 and data_ready=1 in the same cycle. Data_out takes the byte and data_valid=1.
  - If data_valid=1 and data_ready=0 when a byte completes: the byte is dropped, Data_out is unchanged, and overflow is set (cleared only by reset). The checksum still includes the dropped byte.
  - Handshake data_valid&data_ready with no new byte: data_valid→0 next cycle; Data_out keeps its last value.
- LEN and CHK bytes never appear on Data_out.
- Back-to-back frames: HUNT is re-entered with fill=0, so the next SYNC must be fully received after the CHK byte.

Test Plan:
1. Reset: assert reset 2 cycles mid-stream. All outputs are 0 and state=0. Feeding 7 bits "1010010" then deasserting produces no frame_start.
2. Good frame, data_ready=1, bit_valid every cycle, bytes A5 02 3C C3 FF:
   - frame_start pulses once.
   - Data_out=3C then C3, each with a one-cycle data_valid.
   - frame_end pulses; frame_err=0; overflow=0.
3. Bad checksum, A5 02 3C C3 00: both payload bytes are delivered; frame_end pulses with frame_err=1. A following good frame (scenario 2) returns frame_err=0.
4. Invalid length:
   - A5 00 → frame_end and frame_err=1, no data_valid, state returns to 0.
   - Repeat with A5 11 (17>MAX_LEN) for the same result.
5. Backpressure, A5 03 11 22 33 00 with data_ready=0:
   - Data_out=11 held valid; 22 and 33 are dropped; overflow=1; frame_err=0.
   - Raising data_ready accepts 11, then data_valid=0.
6. Alignment and gaps:
   - Prefix bits 0,1,1, then A5 02 3C C3 FF with bit_valid toggling 1/0 every cycle: framing is identical to scenario 2 at half rate.
   - Reset during the payload byte C3: no further data_valid until a new SYNC arrives.
